// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: sequences the camera-to-LCD line FIFO (flush, fill, run, drain); optional FSYNC_PIX_MASK_EN adds a registered black-pixel mask
module frame_sync_ctrl #(
  parameter int CNT_W          = 12,
  parameter int FILL_THRESH    = 1024,
  parameter int FLUSH_CYCLES   = 16,
  parameter int VS_ACTIVE_HIGH = 1,
  parameter int ERR_W          = 8
) (
  input  logic             video_clk,
  input  logic             rst_n,
  input  logic             cmos_vsync,
  input  logic [CNT_W-1:0] fifo_rd_count,
  input  logic             fifo_empty,
  input  logic             lcd_de,
  input  logic             lcd_vs,
  output logic             fifo_rst,
  output logic             fifo_rd_en,
  output logic             timing_en,
  output logic             locked,
  output logic [ERR_W-1:0] underflow_cnt,
  output logic [2:0]       state_o,
  output logic             pix_mask
);
  localparam logic ACT = VS_ACTIVE_HIGH != 0;
  localparam int   FW  = $clog2(FLUSH_CYCLES);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_VS = 3'd1, FLUSH = 3'd2, FILL = 3'd3, RUN = 3'd4, DRAIN = 3'd5} state_t;
  state_t          state, nxt;
  logic            vs_meta, vs_sync, vs_d, lcd_vs_d, thr_ok;
  logic            frame_start, vs_rise, uflow;
  logic [FW-1:0]   flush_cnt;
  assign frame_start = (vs_d == ACT) && (vs_sync != ACT);
  assign vs_rise     = lcd_vs && !lcd_vs_d;
  assign uflow       = (state == RUN) && lcd_de && fifo_empty;
  assign fifo_rd_en  = (state == RUN) && lcd_de && !fifo_empty;
  assign state_o     = state;
  // camera vsync synchroniser plus edge register, lcd_vs edge register and registered fill compare
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta  <= ~ACT;
      vs_sync  <= ~ACT;
      vs_d     <= ~ACT;
      lcd_vs_d <= 1'b0;
      thr_ok   <= 1'b0;
    end else begin
      vs_meta  <= cmos_vsync;
      vs_sync  <= vs_meta;
      vs_d     <= vs_sync;
      lcd_vs_d <= lcd_vs;
      thr_ok   <= fifo_rd_count >= CNT_W'(FILL_THRESH);
    end
  end
  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = WAIT_VS;
      WAIT_VS: nxt = frame_start ? FLUSH : WAIT_VS;
      FLUSH:   nxt = (flush_cnt == '0) ? FILL : FLUSH;
      FILL:    nxt = thr_ok ? RUN : FILL;
      RUN:     nxt = uflow ? DRAIN : RUN;
      DRAIN:   nxt = vs_rise ? WAIT_VS : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // state register; outputs are registered from the next state so they change together with state_o
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fifo_rst      <= 1'b1;
      timing_en     <= 1'b0;
      locked        <= 1'b0;
      flush_cnt     <= '0;
      underflow_cnt <= '0;
    end else begin
      state     <= nxt;
      fifo_rst  <= nxt inside {IDLE, WAIT_VS, FLUSH};
      timing_en <= nxt inside {RUN, DRAIN};
      locked    <= nxt == RUN;
      flush_cnt <= (state == FLUSH) ? flush_cnt - 1'b1 : FW'(FLUSH_CYCLES - 1);
      if (uflow && !(&underflow_cnt))
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end
`ifdef FSYNC_PIX_MASK_EN
  // mask delayed one cycle to line up with the FIFO read data
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) pix_mask <= 1'b0;
    else        pix_mask <= lcd_de && !locked;
  end
`else
  assign pix_mask = 1'b0;
`endif
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: table vectors and hand sequences checking frame_sync_ctrl with default parameters
module tb_frame_sync_ctrl;
  logic        video_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic [11:0] fifo_rd_count = '0;
  logic        fifo_empty = 1'b0;
  logic        lcd_de = 1'b0;
  logic        lcd_vs = 1'b0;
  logic        fifo_rst, fifo_rd_en, timing_en, locked, pix_mask;
  logic [7:0]  underflow_cnt;
  logic [2:0]  state_o;
  int          total = 0;
  int          bad = 0;
  logic        pm_bad = 1'b0;
`ifdef FSYNC_PIX_MASK_EN
  localparam logic PM = 1'b1;
`else
  localparam logic PM = 1'b0;
`endif
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_FLUSH = 3'd2, S_FILL = 3'd3, S_RUN = 3'd4, S_DRAIN = 3'd5;
  typedef struct {
    logic       de;
    logic       empty;
    logic       rd_en;
    logic [2:0] st;
  } vec_t;
  vec_t       vt[6];
  logic [2:0] sb[$];

  frame_sync_ctrl dut (
    .video_clk(video_clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync),
    .fifo_rd_count(fifo_rd_count), .fifo_empty(fifo_empty), .lcd_de(lcd_de), .lcd_vs(lcd_vs),
    .fifo_rst(fifo_rst), .fifo_rd_en(fifo_rd_en), .timing_en(timing_en), .locked(locked),
    .underflow_cnt(underflow_cnt), .state_o(state_o), .pix_mask(pix_mask)
  );

  always #5 video_clk = ~video_clk;

  always @(negedge video_clk) if (pix_mask !== 1'b0) pm_bad = 1'b1;

  task automatic step();
    @(posedge video_clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int n = 0;
    while (state_o !== s && n < budget) begin
      step();
      n++;
    end
    chk(nm, state_o, s);
  endtask

  task automatic frame_pulse();
    cmos_vsync = 1'b1;
    repeat (3) step();
    cmos_vsync = 1'b0;
    wait_state(S_FLUSH, 6, "frame_to_flush");
  endtask

  task automatic uf_round();
    frame_pulse();
    wait_state(S_RUN, 40, "round_run");
    lcd_de = 1'b1;
    fifo_empty = 1'b1;
    step();
    lcd_de = 1'b0;
    fifo_empty = 1'b0;
    chk("round_drain", state_o, S_DRAIN);
    lcd_vs = 1'b1;
    step();
    lcd_vs = 1'b0;
    wait_state(S_WAIT, 2, "round_wait");
  endtask

  initial begin
    int fill_bad = 0;
    vt[0] = '{1'b1, 1'b0, 1'b1, S_RUN};
    vt[1] = '{1'b0, 1'b0, 1'b0, S_RUN};
    vt[2] = '{1'b0, 1'b1, 1'b0, S_RUN};
    vt[3] = '{1'b1, 1'b0, 1'b1, S_RUN};
    vt[4] = '{1'b1, 1'b0, 1'b1, S_RUN};
    vt[5] = '{1'b1, 1'b1, 1'b0, S_DRAIN};
    #12;
    chk("rst_state", state_o, S_IDLE);
    chk("rst_fifo_rst", fifo_rst, 1);
    chk("rst_timing_en", timing_en, 0);
    chk("rst_locked", locked, 0);
    chk("rst_uf_cnt", underflow_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_pix_mask", pix_mask, 0);
    rst_n = 1'b1;
    step();
    chk("idle_to_wait", state_o, S_WAIT);
    cmos_vsync = 1'b1;
    repeat (98) step();
    chk("vs_high_no_start", state_o, S_WAIT);
    cmos_vsync = 1'b0;
    step();
    chk("vs_lat1", state_o, S_WAIT);
    step();
    chk("vs_lat2", state_o, S_WAIT);
    step();
    chk("vs_lat3_flush", state_o, S_FLUSH);
    for (int i = 0; i < 16; i++) begin
      chk("flush_state", state_o, S_FLUSH);
      chk("flush_rst", fifo_rst, 1);
      step();
    end
    chk("fill_state", state_o, S_FILL);
    chk("fill_rst_low", fifo_rst, 0);
    for (int c = 0; c < 1024; c++) begin
      fifo_rd_count = 12'(c);
      step();
      if (state_o !== S_FILL || timing_en !== 1'b0) fill_bad++;
    end
    chk("fill_ramp_hold", fill_bad, 0);
    fifo_rd_count = 12'd1024;
    step();
    chk("thr_reg_delay", state_o, S_FILL);
    step();
    chk("run_state", state_o, S_RUN);
    chk("run_timing_en", timing_en, 1);
    chk("run_locked", locked, 1);
    chk("pre_uf_cnt", underflow_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      lcd_de = vt[i].de;
      fifo_empty = vt[i].empty;
      #1;
      chk("vec_rd_en", fifo_rd_en, vt[i].rd_en);
      sb.push_back(vt[i].st);
      step();
      chk("vec_state", state_o, sb.pop_front());
    end
    chk("uf_cnt_one", underflow_cnt, 1);
    chk("drain_locked", locked, 0);
    chk("drain_timing_en", timing_en, 1);
    repeat (4) step();
    chk("uf_cnt_still_one", underflow_cnt, 1);
    chk("drain_hold", state_o, S_DRAIN);
    chk("drain_pix_mask", pix_mask, PM);
    fifo_empty = 1'b0;
    #1;
    chk("drain_rd_en", fifo_rd_en, 0);
    lcd_de = 1'b0;
    cmos_vsync = 1'b1;
    repeat (3) step();
    cmos_vsync = 1'b0;
    repeat (5) step();
    chk("drain_ignores_vs", state_o, S_DRAIN);
    lcd_vs = 1'b1;
    step();
    chk("drain_to_wait", state_o, S_WAIT);
    chk("wait_timing_off", timing_en, 0);
    lcd_vs = 1'b0;
    fifo_rd_count = '0;
    frame_pulse();
    wait_state(S_FILL, 20, "second_fill");
    cmos_vsync = 1'b1;
    repeat (3) step();
    cmos_vsync = 1'b0;
    repeat (5) step();
    chk("fill_ignores_vs", state_o, S_FILL);
    fifo_rd_count = 12'd1024;
    wait_state(S_RUN, 4, "second_run");
    lcd_de = 1'b1;
    fifo_empty = 1'b1;
    step();
    lcd_de = 1'b0;
    fifo_empty = 1'b0;
    chk("uf_cnt_two", underflow_cnt, 2);
    lcd_vs = 1'b1;
    step();
    lcd_vs = 1'b0;
    wait_state(S_WAIT, 2, "second_wait");
    repeat (252) uf_round();
    chk("uf_cnt_254", underflow_cnt, 254);
    uf_round();
    chk("uf_cnt_255", underflow_cnt, 255);
    repeat (2) uf_round();
    chk("uf_cnt_sat", underflow_cnt, 255);
    frame_pulse();
    wait_state(S_RUN, 40, "final_run");
    lcd_de = 1'b1;
    fifo_empty = 1'b0;
    step();
    chk("final_rd_en", fifo_rd_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fifo_rst", fifo_rst, 1);
    chk("mid_rst_timing_en", timing_en, 0);
    chk("mid_rst_uf_cnt", underflow_cnt, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_state", state_o, S_IDLE);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    lcd_de = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("restart_wait", state_o, S_WAIT);
    chk("restart_uf_cnt", underflow_cnt, 0);
`ifndef FSYNC_PIX_MASK_EN
    chk("pix_mask_never", pm_bad, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
